// File: rtl/divider_pkg.sv
// ----------------------------------------------------------------------------
// divider_pkg
// Shared definitions for the sequential signed divider: datapath width,
// iteration count, counter width, FSM state encoding, the two operand values
// that form the overflow case, and small two's-complement helpers.
// ----------------------------------------------------------------------------
package divider_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = 6;

    localparam logic [DIV_WIDTH-1:0] INT_MIN = 32'h8000_0000;
    localparam logic [DIV_WIDTH-1:0] NEG_ONE = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } divState_t;

    // Two's-complement negation; INT_MIN maps onto itself, which is exactly
    // what both the magnitude step and the final sign fix need.
    function automatic logic [DIV_WIDTH-1:0] negate(input logic [DIV_WIDTH-1:0] x);
        return ~x + DIV_WIDTH'(1);
    endfunction

    // Magnitude of a signed operand, read as unsigned.
    function automatic logic [DIV_WIDTH-1:0] absVal(input logic [DIV_WIDTH-1:0] x);
        return x[DIV_WIDTH-1] ? negate(x) : x;
    endfunction

endpackage

// File: rtl/divider_cla.sv
// ----------------------------------------------------------------------------
// divider_cla
// Carry-lookahead adder built from 4-bit lookahead groups rippling between
// groups. The divider uses it as its trial subtractor (b = ~D, cin = 1).
// Ports:
//   a, b  : W-bit addends
//   cin   : carry in
//   sum   : W-bit sum
//   cout  : carry out of the top bit
// ----------------------------------------------------------------------------
module divider_cla
    import divider_pkg::*;
#(
    parameter int W = DIV_WIDTH
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W-1:0] gen;
    logic [W-1:0] prop;
    logic [W:0]   carry;

    assign gen  = a & b;
    assign prop = a ^ b;

    // Each 4-bit group derives all its internal carries directly from the
    // group's carry-in, so only the group carries ripple.
    always_comb begin
        carry    = '0;
        carry[0] = cin;
        for (int gi = 0; gi < W / 4; gi++) begin
            int base;
            base = gi * 4;
            carry[base+1] = gen[base] | (prop[base] & carry[base]);
            carry[base+2] = gen[base+1]
                          | (prop[base+1] & gen[base])
                          | (prop[base+1] & prop[base] & carry[base]);
            carry[base+3] = gen[base+2]
                          | (prop[base+2] & gen[base+1])
                          | (prop[base+2] & prop[base+1] & gen[base])
                          | (prop[base+2] & prop[base+1] & prop[base] & carry[base]);
            carry[base+4] = gen[base+3]
                          | (prop[base+3] & gen[base+2])
                          | (prop[base+3] & prop[base+2] & gen[base+1])
                          | (prop[base+3] & prop[base+2] & prop[base+1] & gen[base])
                          | (prop[base+3] & prop[base+2] & prop[base+1] & prop[base] & carry[base]);
        end
    end

    assign sum  = prop ^ carry[W-1:0];
    assign cout = carry[W];

endmodule

// File: rtl/divider.sv
// ----------------------------------------------------------------------------
// divider
// Sequential 32-bit signed divider (restoring, one quotient bit per cycle).
// Quotient truncates toward zero; divide-by-zero and INT_MIN / -1 raise
// data_exception with a zero result. Fixed latency of 33 cycles from start.
// Ports:
//   clock, reset    : clock and asynchronous active-high reset
//   ctrl_DIV        : start strobe (restarts if a division is in flight)
//   data_operandA/B : dividend / divisor, sampled on the start edge
//   data_result     : quotient, held until the next ready pulse
//   data_exception  : exception flag, valid with the result
//   data_resultRDY  : one-cycle pulse marking the result valid
//   busy            : high while iterating
// ----------------------------------------------------------------------------
module divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    divState_t        state;
    divState_t        nextState;
    logic [CNT_W-1:0] iterCount;
    logic [WIDTH-1:0] remReg;
    logic [WIDTH-1:0] quoReg;
    logic [WIDTH-1:0] divReg;
    logic             signReg;
    logic             excReg;
    logic             iterate;
    logic             finish;
    logic [WIDTH-1:0] remShift;
    logic [WIDTH-1:0] trialDiff;
    logic             noBorrow;
    logic             startExc;

    // Since R < D <= 2^31, the shifted partial remainder always fits in
    // 32 unsigned bits, so no guard bit is needed.
    assign remShift = {remReg[WIDTH-2:0], quoReg[WIDTH-1]};

    assign startExc = (data_operandB == '0)
                    || ((data_operandA == INT_MIN) && (data_operandB == NEG_ONE));

    // Trial subtraction R' - D as R' + ~D + 1; carry out means no borrow.
    divider_cla #(.W(WIDTH)) cla (
        .a    (remShift),
        .b    (~divReg),
        .cin  (1'b1),
        .sum  (trialDiff),
        .cout (noBorrow)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic: a start strobe always (re)enters ITER, even from
    // DONE, which lets back-to-back divisions overlap the ready cycle.
    always_comb begin
        nextState = state;
        if (ctrl_DIV) begin
            nextState = ITER;
        end else begin
            case (state)
                IDLE:    nextState = IDLE;
                ITER:    if (iterCount == CNT_W'(DIV_ITERS - 1)) nextState = DONE;
                DONE:    nextState = IDLE;
                default: nextState = IDLE;
            endcase
        end
    end

    // State decode for the datapath and the busy flag.
    always_comb begin
        iterate = (state == ITER);
        finish  = (state == DONE);
        busy    = (state == ITER);
    end

    // Datapath and registered outputs. The DONE edge publishes the old
    // quotient while a coincident start loads the new operands, so the
    // pending result is never lost to a restart in the DONE cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            iterCount      <= '0;
            remReg         <= '0;
            quoReg         <= '0;
            divReg         <= '0;
            signReg        <= 1'b0;
            excReg         <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= finish;
            if (finish) begin
                data_result    <= excReg  ? '0 :
                                  signReg ? negate(quoReg) : quoReg;
                data_exception <= excReg;
            end
            if (ctrl_DIV) begin
                quoReg    <= absVal(data_operandA);
                divReg    <= absVal(data_operandB);
                remReg    <= '0;
                iterCount <= '0;
                signReg   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                excReg    <= startExc;
            end else if (iterate) begin
                remReg    <= noBorrow ? trialDiff : remShift;
                quoReg    <= {quoReg[WIDTH-2:0], noBorrow};
                iterCount <= iterCount + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_divider.sv
// ----------------------------------------------------------------------------
// tb_divider
// Scoreboard bench for the signed divider: every start pushes the expected
// quotient, exception flag and ready cycle; the monitor pops and compares on
// each ready pulse.
// ----------------------------------------------------------------------------
module tb_divider;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    typedef struct {
        logic [31:0] result;
        logic        exc;
        int          readyAt;
    } expect_t;

    expect_t sb[$];
    int      cycle = 0;
    int      compared = 0;
    int      mismatched = 0;

    divider dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    // Free-running clock and a count of rising edges seen so far.
    always #5 clock = ~clock;

    always @(posedge clock) cycle = cycle + 1;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
                     tag, actual, expected, cycle);
        end
    endtask

    // Independent reference: SystemVerilog signed division truncates toward
    // zero, with the two exception cases handled explicitly.
    task automatic modelDiv(input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] res, output logic exc);
        if (b == 32'd0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) begin
            res = 32'd0;
            exc = 1'b1;
        end else begin
            res = 32'($signed(a) / $signed(b));
            exc = 1'b0;
        end
    endtask

    // Drive one start strobe from a falling edge. A start before the pending
    // result's ready edge aborts it, so that entry leaves the scoreboard.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expRes, input logic expExc);
        expect_t e;
        int      startEdge;
        startEdge = cycle + 1;
        if (sb.size() != 0 && sb[$].readyAt > startEdge) void'(sb.pop_back());
        e.result  = expRes;
        e.exc     = expExc;
        e.readyAt = startEdge + 33;
        sb.push_back(e);
        ctrl_DIV      = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(negedge clock);
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Wait (bounded) for the scoreboard to drain.
    task automatic waitDrain(input string tag);
        for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge clock);
        checkOutput(tag, 32'(sb.size()), 32'd0);
    endtask

    task automatic runOne(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expRes, input logic expExc);
        applyStimulus(a, b, expRes, expExc);
        waitDrain("drain");
    endtask

    // Monitor: every ready pulse must match the oldest expected entry,
    // including the exact cycle it was due in.
    always @(negedge clock) begin
        if (!reset && data_resultRDY) begin
            if (sb.size() == 0) begin
                checkOutput("spurious ready", 32'd1, 32'd0);
            end else begin
                expect_t e;
                e = sb.pop_front();
                checkOutput("result", data_result, e.result);
                checkOutput("exception", 32'(data_exception), 32'(e.exc));
                checkOutput("latency", 32'(cycle), 32'(e.readyAt));
            end
        end
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] rr;
        logic        re;

        repeat (2) @(negedge clock);
        checkOutput("reset result", data_result, 32'd0);
        checkOutput("reset exception", 32'(data_exception), 32'd0);
        checkOutput("reset ready", 32'(data_resultRDY), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // 100 / 7 with busy tracked across the iteration window.
        applyStimulus(32'd100, 32'd7, 32'd14, 1'b0);
        checkOutput("busy after start", 32'(busy), 32'd1);
        repeat (31) @(negedge clock);
        checkOutput("busy last iter", 32'(busy), 32'd1);
        @(negedge clock);
        checkOutput("busy in done", 32'(busy), 32'd0);
        waitDrain("drain 100/7");
        checkOutput("busy idle", 32'(busy), 32'd0);

        // Sign combinations.
        runOne(-32'sd100, 32'd7, 32'hFFFF_FFF2, 1'b0);
        runOne(32'd100, -32'sd7, 32'hFFFF_FFF2, 1'b0);
        runOne(-32'sd100, -32'sd7, 32'd14, 1'b0);

        // Divide by zero, then a normal op clears the flag.
        runOne(32'd5, 32'd0, 32'd0, 1'b1);
        runOne(32'd9, 32'd3, 32'd3, 1'b0);

        // Overflow case and INT_MIN by one.
        runOne(32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1);
        runOne(32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0);

        // Restart mid-division: only the second result appears, 33 cycles
        // after its own start.
        applyStimulus(32'd100, 32'd7, 32'd14, 1'b0);
        repeat (9) @(negedge clock);
        applyStimulus(32'd9, 32'd3, 32'd3, 1'b0);
        waitDrain("drain abort");

        // Start in the DONE cycle: the pending pulse still completes.
        applyStimulus(32'd1000, 32'd10, 32'd100, 1'b0);
        repeat (32) @(negedge clock);
        applyStimulus(-32'sd50, 32'd5, 32'hFFFF_FFF6, 1'b0);
        waitDrain("drain done restart");

        // Random operands checked against the reference model.
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (i == 3) rb = -32'sd3;
            modelDiv(ra, rb, rr, re);
            runOne(ra, rb, rr, re);
        end

        // Reset mid-division clears outputs at once and suppresses the pulse.
        runOne(-32'sd100, 32'd7, 32'hFFFF_FFF2, 1'b0);
        applyStimulus(32'd100, 32'd7, 32'd14, 1'b0);
        repeat (14) @(negedge clock);
        reset = 1'b1;
        #1;
        sb.delete();
        checkOutput("reset mid result", data_result, 32'd0);
        checkOutput("reset mid exception", 32'(data_exception), 32'd0);
        checkOutput("reset mid ready", 32'(data_resultRDY), 32'd0);
        checkOutput("reset mid busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        runOne(32'h7FFF_FFFF, 32'd2, 32'h3FFF_FFFF, 1'b0);

        repeat (3) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
